fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 35 +++
 rtl/fetch_queue_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_fetch_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fq_types                                                      |
// | Description : Shared types and constants for the fetch_queue front end:     |
// |               fetch FSM state encoding, queue entry layout, JAL opcode,     |
// |               sequential PC step and the J-type immediate extractor.        |
// | Optional    : FQ_JAL_PREDICT_EN (consumers use OP_JAL / jal_offset)         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fq_types;

    localparam int         FQ_XLEN    = 32;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam int         FQ_PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fq_state_t;

    // Logical content of one queue slot (shown for the default 32-bit width).
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
        logic               pred_taken;
    } fq_entry_t;

    // Byte offset encoded in a JAL instruction, 21 bits, sign bit at [20].
    function automatic logic [20:0] jal_offset(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fq_fifo                                                       |
// | Description : DEPTH-entry circular buffer with push, pop, flush and an      |
// |               occupancy count. Head data is read combinationally.           |
// | Ports       : clk, rst        clock, synchronous active-high reset          |
// |               i_push/i_push_data  write one entry at the tail               |
// |               i_pop           advance the head                              |
// |               i_flush         empty the buffer (wins over push/pop)         |
// |               o_head_data     entry at the head                             |
// |               o_count         occupancy, 0..DEPTH                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_AW:0]    r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop)  r_head <= r_head + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once it was written.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) r_mem[r_tail] <= i_push_data;
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                   |
// | Description : Decoupled rv32i instruction fetch. Issues one outstanding     |
// |               request at a time to instruction memory, buffers {pc, inst}   |
// |               in a circular FIFO and hands the head to ID under valid/ready.|
// |               A redirect flushes the queue and restarts fetch; a response   |
// |               still in flight at that moment is discarded.                  |
// | Ports       : clk, rst                 clock, sync active-high reset        |
// |               redirect, redirect_pc    flush + new fetch address            |
// |               inst_read, inst_addr     memory request (held until resp)     |
// |               inst_rdata, inst_resp    memory response (one-cycle strobe)   |
// |               fq_valid, fq_ready       head handshake towards ID            |
// |               fq_pc, fq_inst, fq_pred_taken  head entry                     |
// |               fq_count                 occupancy                            |
// | Optional    : FQ_JAL_PREDICT_EN - follow JAL targets at fetch and mark the  |
// |               entry pred_taken; otherwise fetch is strictly sequential.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fetch_queue
    import fq_types::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   inst_read,
    output logic [XLEN-1:0]        inst_addr,
    input  logic [XLEN-1:0]        inst_rdata,
    input  logic                   inst_resp,
    output logic                   fq_valid,
    input  logic                   fq_ready,
    output logic [XLEN-1:0]        fq_pc,
    output logic [XLEN-1:0]        fq_inst,
    output logic                   fq_pred_taken,
    output logic [$clog2(DEPTH):0] fq_count
);

    localparam int            c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0] c_DEPTH_M1  = (c_AW + 1)'(DEPTH - 1);
`ifdef FQ_JAL_PREDICT_EN
    localparam int            c_ENTRY_W   = 2 * XLEN + 1;
`else
    localparam int            c_ENTRY_W   = 2 * XLEN;
`endif

    fq_state_t          r_state, w_state_nxt;
    logic [XLEN-1:0]    r_fetch_pc, w_fetch_pc_nxt;
    logic [XLEN-1:0]    r_req_addr, w_req_addr_nxt;

    logic [c_AW:0]      w_count;
    logic               w_push;
    logic               w_pop;
    logic               w_room_after;
    logic [XLEN-1:0]    w_seq_pc;
    logic [XLEN-1:0]    w_next_pc;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head_data;

    // Redirect suppresses both queue operations in its cycle.
    assign fq_valid = (w_count != '0);
    assign w_pop    = fq_valid && fq_ready && !redirect;
    assign w_push   = (r_state == REQ) && inst_resp && !redirect;
    assign w_seq_pc = r_req_addr + XLEN'(FQ_PC_STEP);

    // After pushing, count+1-pop < DEPTH  <=>  count < DEPTH-1 or a pop happens.
    assign w_room_after = (w_count < c_DEPTH_M1) || w_pop;

`ifdef FQ_JAL_PREDICT_EN
    logic        w_is_jal;
    logic [20:0] w_jal_imm;
    logic        w_head_pred;

    assign w_is_jal    = (inst_rdata[6:0] == OP_JAL);
    assign w_jal_imm   = jal_offset(inst_rdata[31:0]);
    assign w_next_pc   = w_is_jal ? r_req_addr + {{(XLEN-21){w_jal_imm[20]}}, w_jal_imm}
                                  : w_seq_pc;
    assign w_push_data = {w_is_jal, r_req_addr, inst_rdata};
    assign {w_head_pred, fq_pc, fq_inst} = w_head_data;
    assign fq_pred_taken = fq_valid && w_head_pred;
`else
    assign w_next_pc     = w_seq_pc;
    assign w_push_data   = {r_req_addr, inst_rdata};
    assign {fq_pc, fq_inst} = w_head_data;
    assign fq_pred_taken = 1'b0;
`endif

    fq_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        inst_read      = 1'b0;

        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_state_nxt    = REQ;
                    w_req_addr_nxt = redirect_pc;
                end else if (w_count < c_DEPTH_CNT) begin
                    w_state_nxt    = REQ;
                    w_req_addr_nxt = r_fetch_pc;
                end
            end

            REQ: begin
                inst_read = 1'b1;
                if (redirect) begin
                    if (inst_resp) begin
                        w_req_addr_nxt = redirect_pc;
                    end else begin
                        // Old request is still in flight; keep its address
                        // on the bus and drop whatever comes back.
                        w_state_nxt = DISCARD;
                    end
                end else if (inst_resp) begin
                    w_fetch_pc_nxt = w_next_pc;
                    if (w_room_after) begin
                        w_req_addr_nxt = w_next_pc;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            DISCARD: begin
                inst_read = 1'b1;
                // A redirect landing on the very response being discarded
                // restarts at the new target; otherwise there would be no
                // request left for DISCARD to wait on.
                if (inst_resp) begin
                    w_state_nxt    = REQ;
                    w_req_addr_nxt = redirect ? redirect_pc : r_fetch_pc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (redirect) w_fetch_pc_nxt = redirect_pc;
    end

    assign inst_addr = r_req_addr;
    assign fq_count  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                                |
// | Description : Self-checking bench for fetch_queue: directed scenarios then  |
// |               randomized traffic, every cycle compared against a queue-     |
// |               based reference model of the fetch front end.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst, redirect, inst_resp, fq_ready;
    logic [31:0] redirect_pc, inst_rdata;
    logic        inst_read, fq_valid, fq_pred_taken;
    logic [31:0] inst_addr, fq_pc, fq_inst;
    logic [2:0]  fq_count;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_read(inst_read), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_resp(inst_resp), .fq_valid(fq_valid), .fq_ready(fq_ready),
        .fq_pc(fq_pc), .fq_inst(fq_inst), .fq_pred_taken(fq_pred_taken),
        .fq_count(fq_count)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic pred; } ent_t;

    // Reference model: a queue of fetched entries plus the outstanding request.
    ent_t        m_q[$];
    bit          m_busy, m_discard;
    logic [31:0] m_req, m_fpc;

    int checks = 0, failures = 0;
    int mem_lat, wait_cnt;
    bit rand_data, spurious, jal_force;

    function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [31:0] jal_target(logic [31:0] pc, logic [31:0] i);
        logic signed [20:0] off;
        off = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        return pc + 32'($signed(off));
    endfunction

    function automatic void model_step(bit resp);
        bit          pop;
        bit          pred;
        int          after;
        logic [31:0] nxt;
        if (rst) begin
            m_q.delete(); m_busy = 0; m_discard = 0; m_req = RESET_PC; m_fpc = RESET_PC;
            return;
        end
        if (redirect) begin
            m_q.delete();
            m_fpc = redirect_pc;
            if (!m_busy || resp) begin m_busy = 1; m_discard = 0; m_req = redirect_pc; end
            else m_discard = 1;
            return;
        end
        pop = fq_ready && (m_q.size() != 0);
        if (!m_busy) begin
            if (m_q.size() < DEPTH) begin m_busy = 1; m_req = m_fpc; end
        end else if (resp && m_discard) begin
            m_discard = 0; m_req = m_fpc;
        end else if (resp) begin
            pred = 0;
            nxt  = m_req + 32'd4;
`ifdef FQ_JAL_PREDICT_EN
            if (inst_rdata[6:0] == 7'b1101111) begin pred = 1; nxt = jal_target(m_req, inst_rdata); end
`endif
            after = m_q.size() + 1 - (pop ? 1 : 0);
            m_q.push_back('{pc: m_req, inst: inst_rdata, pred: pred});
            m_fpc = nxt;
            if (after < DEPTH) m_req = nxt;
            else m_busy = 0;
        end
        if (pop) void'(m_q.pop_front());
    endfunction

    function automatic void check_outputs();
        chk("inst_read", 64'(inst_read), 64'(m_busy));
        chk("inst_addr", 64'(inst_addr), 64'(m_req));
        chk("fq_valid",  64'(fq_valid),  64'(m_q.size() != 0));
        chk("fq_count",  64'(fq_count),  64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("fq_pc",         64'(fq_pc),         64'(m_q[0].pc));
            chk("fq_inst",       64'(fq_inst),       64'(m_q[0].inst));
            chk("fq_pred_taken", 64'(fq_pred_taken), 64'(m_q[0].pred));
        end else begin
            chk("fq_pred_idle",  64'(fq_pred_taken), 64'd0);
        end
    endfunction

    // One clock: memory responds to the model's outstanding request after
    // wait_cnt idle cycles; caller has already set rst/redirect/fq_ready.
    task automatic tick();
        bit resp;
        resp = 0;
        inst_resp = 1'b0;
        if (m_busy) begin
            if (wait_cnt == 0) resp = 1;
            else wait_cnt--;
        end
        inst_resp = resp || (!m_busy && spurious && $urandom_range(0, 3) == 0);
        if (rand_data) inst_rdata = $urandom;
        else if (jal_force && m_req == 32'h60) inst_rdata = 32'h1000_006F;
        else inst_rdata = {m_req[24:0], 7'h13};
        if (resp) wait_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        model_step(resp);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(int lat);
        rst = 1'b1; redirect = 1'b0; fq_ready = 1'b0;
        mem_lat = lat; wait_cnt = lat;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; fq_ready = 1'b0;
        inst_resp = 1'b0; inst_rdata = '0;
        rand_data = 0; spurious = 0; jal_force = 0;
        m_busy = 0; m_discard = 0; m_req = RESET_PC; m_fpc = RESET_PC;

        // Back-to-back fetch with zero-wait memory and ID always ready.
        do_reset(0);
        chk("rst_inst_addr", 64'(inst_addr), 64'h60);
        chk("rst_inst_read", 64'(inst_read), 64'd0);
        chk("rst_count",     64'(fq_count),  64'd0);
        fq_ready = 1'b1;
        tick();
        chk("t1_valid_lat1", 64'(fq_valid), 64'd0);
        tick();
        chk("t1_valid_lat2", 64'(fq_valid), 64'd1);
        chk("t1_pc0", 64'(fq_pc), 64'h60);
        tick();
        chk("t1_pc1", 64'(fq_pc), 64'h64);
        tick();
        chk("t1_pc2", 64'(fq_pc), 64'h68);

        // Fill with ID stalled, then a single pop re-arms one request.
        do_reset(0);
        repeat (8) tick();
        chk("t2_full_count", 64'(fq_count),  64'd4);
        chk("t2_full_read",  64'(inst_read), 64'd0);
        chk("t2_head",       64'(fq_pc),     64'h60);
        fq_ready = 1'b1;
        tick();
        fq_ready = 1'b0;
        chk("t2_after_pop", 64'(fq_count), 64'd3);
        tick();
        chk("t2_refetch_read", 64'(inst_read), 64'd1);
        chk("t2_refetch_addr", 64'(inst_addr), 64'h70);
        tick();
        chk("t2_refill", 64'(fq_count), 64'd4);

        // Three-cycle memory latency: address held until the response.
        do_reset(2);
        fq_ready = 1'b1;
        tick();
        chk("t3_hold0", 64'(inst_addr), 64'h60);
        tick();
        chk("t3_hold1", 64'(inst_addr), 64'h60);
        tick();
        chk("t3_hold2", 64'(inst_addr), 64'h60);
        chk("t3_nopush", 64'(fq_valid), 64'd0);
        tick();
        chk("t3_push_pc",  64'(fq_pc),     64'h60);
        chk("t3_next_req", 64'(inst_addr), 64'h64);
        repeat (12) tick();

        // Redirect while a request is outstanding: its response is dropped.
        do_reset(0);
        fq_ready = 1'b1;
        tick();
        mem_lat = 3;
        tick();
        chk("t4_req64", 64'(inst_addr), 64'h64);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("t4_discard_addr",  64'(inst_addr), 64'h64);
        chk("t4_flushed",       64'(fq_valid),  64'd0);
        mem_lat = 0;
        for (int i = 0; i < 20 && fq_valid !== 1'b1; i++) tick();
        chk("t4_first_valid", 64'(fq_valid), 64'd1);
        chk("t4_first_pc",    64'(fq_pc),    64'h200);

        // Redirect coinciding with a response and a pop at count 2.
        do_reset(0);
        repeat (3) tick();
        chk("t5_count2", 64'(fq_count), 64'd2);
        fq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0; fq_ready = 1'b0;
        chk("t5_count0", 64'(fq_count),  64'd0);
        chk("t5_read",   64'(inst_read), 64'd1);
        chk("t5_addr",   64'(inst_addr), 64'h300);
        tick();
        chk("t5_new_head", 64'(fq_pc), 64'h300);

        // JAL at 0x60 with offset +0x100.
        jal_force = 1;
        do_reset(0);
        tick(); tick();
`ifdef FQ_JAL_PREDICT_EN
        chk("t6_jal_next", 64'(inst_addr),     64'h160);
        chk("t6_jal_pred", 64'(fq_pred_taken), 64'd1);
`else
        chk("t6_jal_next", 64'(inst_addr),     64'h64);
        chk("t6_jal_pred", 64'(fq_pred_taken), 64'd0);
`endif
        jal_force = 0;

        // Randomized traffic: latency, backpressure, redirects, resets.
        do_reset(-1);
        rand_data = 1; spurious = 1;
        for (int n = 0; n < 2000; n++) begin
            fq_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            rpc         = $urandom;
            rpc[1:0]    = 2'b00;
            redirect_pc = rpc;
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; redirect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
